// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller for a dual-port RAM (port A writes, port B reads).
// Optional sticky overflow flag is compiled in when DPRAM_FIFO_CTRL_OVF_EN is defined.
module dpram_fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  ovf_err,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_din_a,
    output logic                  ram_we_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
);

    localparam int unsigned PtrW = ADDR_WIDTH + 1;
    localparam logic [PtrW-1:0] FullCount = PtrW'((2 ** ADDR_WIDTH) + 2);

    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q, ram_words;
    logic                  rd_pend_q;
    logic [1:0]            skid_cnt_q, skid_cnt_d, skid_after_pop;
    logic [DATA_WIDTH-1:0] head_q, head_d, spare_q, spare_d;
    logic                  push, pop, issue;
    logic [2:0]            skid_demand;

    assign ram_words = wr_ptr_q - rd_ptr_q;
    assign count     = ram_words + PtrW'(rd_pend_q) + PtrW'(skid_cnt_q);
    assign full      = (count == FullCount);
    assign empty     = (count == '0);
    assign s_ready   = !full;
    assign m_valid   = (skid_cnt_q != 2'd0);
    assign m_data    = head_q;

    // rst_n gating keeps port A idle while reset is held, even with s_valid high.
    assign push = s_valid && s_ready && rst_n;
    assign pop  = m_valid && m_ready;

    // Skid slots still needed next cycle; a new read is only issued if one stays free.
    assign skid_demand = {1'b0, skid_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    assign issue       = (ram_words != '0) && (skid_demand < 3'd2);

    assign ram_we_a   = push;
    assign ram_addr_a = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_din_a  = push ? s_data : '0;
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = rd_ptr_q[ADDR_WIDTH-1:0];

    always_comb begin
        head_d         = head_q;
        spare_d        = spare_q;
        skid_after_pop = skid_cnt_q;
        if (pop) begin
            skid_after_pop = skid_cnt_q - 2'd1;
            if (skid_cnt_q == 2'd2) begin
                head_d = spare_q;
            end
        end
        // Captured word lands in the first slot left free after the pop.
        if (rd_pend_q) begin
            if (skid_after_pop == 2'd0) begin
                head_d = ram_dout_b;
            end else begin
                spare_d = ram_dout_b;
            end
        end
        skid_cnt_d = skid_after_pop + {1'b0, rd_pend_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_pend_q  <= 1'b0;
            skid_cnt_q <= 2'd0;
            head_q     <= '0;
            spare_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (issue) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            rd_pend_q  <= issue;
            skid_cnt_q <= skid_cnt_d;
            head_q     <= head_d;
            spare_q    <= spare_d;
        end
    end

`ifdef DPRAM_FIFO_CTRL_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (s_valid && full) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;
`else
    assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl with a behavioural dual-port RAM and a queue
// scoreboard of accepted words.
module tb_dpram_fifo_ctrl;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 66;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [AW:0]   count;
    logic          full, empty, ovf_err;
    logic          ram_we_a, ram_we_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_din_a;
    logic [DW-1:0] ram_dout_b = '0;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] exp_q [$];
    int            errors = 0;
    int            checks = 0;
    int            pops   = 0;
    logic          exp_ovf;

    dpram_fifo_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .ovf_err    (ovf_err),
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_we_b   (ram_we_b),
        .ram_addr_b (ram_addr_b),
        .ram_dout_b (ram_dout_b)
    );

    always #5 clk = ~clk;

    // Registered-read RAM; a same-address write/read returns the old word.
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_b <= mem[ram_addr_b];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Samples mid-cycle, scores the handshakes of this cycle, then advances past the edge.
    task automatic tick();
        #2;
        check_eq("count", 32'(count), 32'(exp_q.size()));
        check_eq("full", 32'(full), 32'(exp_q.size() == DEPTH));
        if (m_valid && m_ready) begin
            pops++;
            check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("m_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
        if (s_valid && s_ready) exp_q.push_back(s_data);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && empty) break;
            tick();
        end
        check_eq("drain_sb_empty", 32'(exp_q.size()), 32'd0);
        check_eq("drain_empty", 32'(empty), 32'd1);
        m_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] prev_addr_b;
        logic          wrapped;
        logic [AW:0]   stream_count;

`ifdef DPRAM_FIFO_CTRL_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_s_ready", 32'(s_ready), 32'd1);
        check_eq("rst_we_a", 32'(ram_we_a), 32'd0);
        check_eq("rst_we_b", 32'(ram_we_b), 32'd0);
        check_eq("rst_m_data", 32'(m_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single word: latency of two edges, held under backpressure
        s_valid = 1'b1;
        s_data  = 8'hAA;
        #1;
        check_eq("single_we_a", 32'(ram_we_a), 32'd1);
        check_eq("single_addr_a", 32'(ram_addr_a), 32'd0);
        check_eq("single_din_a", 32'(ram_din_a), 32'hAA);
        tick();
        s_valid = 1'b0;
        check_eq("single_mv_n", 32'(m_valid), 32'd0);
        tick();
        check_eq("single_mv_n1", 32'(m_valid), 32'd0);
        tick();
        check_eq("single_mv_n2", 32'(m_valid), 32'd1);
        check_eq("single_data_n2", 32'(m_data), 32'hAA);
        tick();
        tick();
        check_eq("single_hold_mv", 32'(m_valid), 32'd1);
        check_eq("single_hold_data", 32'(m_data), 32'hAA);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check_eq("single_empty", 32'(empty), 32'd1);
        check_eq("single_mv_gone", 32'(m_valid), 32'd0);

        // Fill to 66 words, then one rejected push
        for (int i = 0; i < DEPTH; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(i);
            tick();
        end
        s_valid = 1'b0;
        check_eq("fill_full", 32'(full), 32'd1);
        check_eq("fill_count", 32'(count), 32'd66);
        check_eq("fill_s_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        #1;
        check_eq("fill_no_we", 32'(ram_we_a), 32'd0);
        tick();
        s_valid = 1'b0;
        check_eq("ovf_count", 32'(count), 32'd66);
        check_eq("ovf_flag", 32'(ovf_err), 32'(exp_ovf));

        // Drain at one word per cycle, watching the read address wrap
        m_ready     = 1'b1;
        pops        = 0;
        wrapped     = 1'b0;
        prev_addr_b = ram_addr_b;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            if (prev_addr_b == AW'(63) && ram_addr_b == AW'(0)) wrapped = 1'b1;
            prev_addr_b = ram_addr_b;
        end
        m_ready = 1'b0;
        check_eq("drain_pops", 32'(pops), 32'd66);
        check_eq("drain_wrap", 32'(wrapped), 32'd1);
        check_eq("drain_end_empty", 32'(empty), 32'd1);
        check_eq("drain_end_mv", 32'(m_valid), 32'd0);
        check_eq("ovf_sticky", 32'(ovf_err), 32'(exp_ovf));

        // Streaming: no bubbles and a constant occupancy once filled
        m_ready      = 1'b1;
        stream_count = '0;
        for (int i = 0; i < 40; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(8'h55 + 8'h10 * i);
            tick();
            if (i == 3) stream_count = count;
            if (i >= 3) begin
                check_eq("stream_mv", 32'(m_valid), 32'd1);
                check_eq("stream_count_steady", 32'(count), 32'(stream_count));
            end
        end
        drain(200);

        // Alternating and random backpressure
        for (int i = 0; i < 40; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(i * 7 + 3);
            m_ready = (i % 2) == 1;
            tick();
        end
        for (int i = 0; i < 80; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain(200);

        // Asynchronous reset in the middle of a stream
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(8'hC0 + i);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_eq("mid_rst_count", 32'(count), 32'd0);
        check_eq("mid_rst_empty", 32'(empty), 32'd1);
        check_eq("mid_rst_mv", 32'(m_valid), 32'd0);
        check_eq("mid_rst_s_ready", 32'(s_ready), 32'd1);
        check_eq("mid_rst_we_a", 32'(ram_we_a), 32'd0);
        check_eq("mid_rst_din_a", 32'(ram_din_a), 32'd0);
        check_eq("mid_rst_m_data", 32'(m_data), 32'd0);
        check_eq("mid_rst_ovf", 32'(ovf_err), 32'd0);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(8'h30 + i);
            tick();
        end
        drain(50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
